// File: rtl/id_decode_pipe.sv
// RV32I decode stage with a main + skid buffer, valid/ready handshake and optional
// load-use stall generation (enabled by defining ID_HAZARD_STALL_EN).
module id_decode_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_memread,
  output logic            out_memtoreg,
  output logic            out_memwrite,
  output logic            out_alusrc,
  output logic            out_regwrite,
  output logic            out_illegal,
  output logic [3:0]      out_aluop,
  output logic [2:0]      out_func3,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic            branch;
    logic            jump;
    logic            memread;
    logic            memtoreg;
    logic            memwrite;
    logic            alusrc;
    logic            regwrite;
    logic            illegal;
    logic [3:0]      aluop;
    logic [2:0]      func3;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  entry_t     dec, m_q, s_q, m_d, s_d;
  logic       m_valid, s_valid, m_valid_d, s_valid_d;
  logic       hazard, accept, fire, m_free;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign f3    = in_instr[14:12];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.func3 = f3;
    case (in_instr[6:0])
      7'b0110011: begin
        dec.regwrite = 1'b1;
        dec.aluop    = {in_instr[30], f3};
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.rd       = in_instr[11:7];
      end
      7'b0010011: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = {(f3 == 3'b101) ? in_instr[30] : 1'b0, f3};
        dec.imm      = sext32(imm_i);
        dec.rs1      = in_instr[19:15];
        dec.rd       = in_instr[11:7];
      end
      7'b0000011: begin
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext32(imm_i);
        dec.rs1      = in_instr[19:15];
        dec.rd       = in_instr[11:7];
      end
      7'b0100011: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext32(imm_s);
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
      end
      7'b1100011: begin
        dec.branch = 1'b1;
        dec.aluop  = 4'b1000;
        dec.imm    = sext32(imm_b);
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
      end
      7'b1101111: begin
        dec.jump     = 1'b1;
        dec.regwrite = 1'b1;
        dec.imm      = sext32(imm_j);
        dec.rd       = in_instr[11:7];
      end
      7'b1100111: begin
        dec.jump     = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext32(imm_i);
        dec.rs1      = in_instr[19:15];
        dec.rd       = in_instr[11:7];
      end
      7'b0110111, 7'b0010111: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.imm      = sext32(imm_u);
        dec.rd       = in_instr[11:7];
      end
      default: dec.illegal = 1'b1;
    endcase
  end

`ifdef ID_HAZARD_STALL_EN
  assign hazard = m_valid & ex_memread & (ex_rd != 5'd0) &
                  ((ex_rd == m_q.rs1) | (ex_rd == m_q.rs2));
`else
  logic unused_ex;
  assign hazard    = 1'b0;
  assign unused_ex = ^{ex_memread, ex_rd};
`endif

  assign out_valid = m_valid & ~hazard;
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign m_free    = ~m_valid | fire;

  // Emptied entries are zeroed so an invalid main entry presents zero fields.
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid;
    s_valid_d = s_valid;
    if (m_free) begin
      if (s_valid) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_d       = accept ? dec : '0;
        s_valid_d = accept;
      end else begin
        m_d       = accept ? dec : '0;
        m_valid_d = accept;
      end
    end else if (accept) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end else begin
      s_d       = s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      m_q      <= '0;
      s_q      <= '0;
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      m_q      <= m_d;
      s_q      <= s_d;
      m_valid  <= m_valid_d;
      s_valid  <= s_valid_d;
      in_ready <= ~s_valid_d;
    end
  end

  assign out_branch   = m_q.branch;
  assign out_jump     = m_q.jump;
  assign out_memread  = m_q.memread;
  assign out_memtoreg = m_q.memtoreg;
  assign out_memwrite = m_q.memwrite;
  assign out_alusrc   = m_q.alusrc;
  assign out_regwrite = m_q.regwrite;
  assign out_illegal  = m_q.illegal;
  assign out_aluop    = m_q.aluop;
  assign out_func3    = m_q.func3;
  assign out_imm      = m_q.imm;
  assign out_rs1      = m_q.rs1;
  assign out_rs2      = m_q.rs2;
  assign out_rd       = m_q.rd;
  assign out_pc       = m_q.pc;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Bench for id_decode_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a queue-based reference model.
module tb_id_decode_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, ex_memread, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [4:0]  ex_rd;

  logic        o_valid, i_ready, o_branch, o_jump, o_memread, o_memtoreg, o_memwrite;
  logic        o_alusrc, o_regwrite, o_illegal;
  logic [3:0]  o_aluop;
  logic [2:0]  o_func3;
  logic [31:0] o_imm, o_pc;
  logic [4:0]  o_rs1, o_rs2, o_rd;

  logic        w_valid, w_ready, w_branch, w_jump, w_memread, w_memtoreg, w_memwrite;
  logic        w_alusrc, w_regwrite, w_illegal;
  logic [3:0]  w_aluop;
  logic [2:0]  w_func3;
  logic [63:0] w_imm, w_pc;
  logic [4:0]  w_rs1, w_rs2, w_rd;

  id_decode_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(i_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .out_valid(o_valid), .out_ready(out_ready),
    .out_branch(o_branch), .out_jump(o_jump), .out_memread(o_memread),
    .out_memtoreg(o_memtoreg), .out_memwrite(o_memwrite), .out_alusrc(o_alusrc),
    .out_regwrite(o_regwrite), .out_illegal(o_illegal), .out_aluop(o_aluop),
    .out_func3(o_func3), .out_imm(o_imm), .out_rs1(o_rs1), .out_rs2(o_rs2),
    .out_rd(o_rd), .out_pc(o_pc)
  );

  id_decode_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .out_valid(w_valid), .out_ready(out_ready),
    .out_branch(w_branch), .out_jump(w_jump), .out_memread(w_memread),
    .out_memtoreg(w_memtoreg), .out_memwrite(w_memwrite), .out_alusrc(w_alusrc),
    .out_regwrite(w_regwrite), .out_illegal(w_illegal), .out_aluop(w_aluop),
    .out_func3(w_func3), .out_imm(w_imm), .out_rs1(w_rs1), .out_rs2(w_rs2),
    .out_rd(w_rd), .out_pc(w_pc)
  );

  typedef struct packed {
    logic        branch, jump, memread, memtoreg, memwrite, alusrc, regwrite, illegal;
    logic [3:0]  aluop;
    logic [2:0]  func3;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
  } dec_t;

  logic [31:0] q_instr[$];
  logic [63:0] q_pc[$];
  logic        m_in_ready;
  logic        exp_fire, exp_acc;
  int          n_checks = 0;
  int          n_fail = 0;

  // Architectural meaning of each opcode, immediates as signed integers.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    bit u1, u2, ud;
    d = '0; u1 = 0; u2 = 0; ud = 0;
    d.func3 = ins[14:12];
    case (ins[6:0])
      7'h33: begin d.regwrite = 1; d.aluop = {ins[30], ins[14:12]}; u1 = 1; u2 = 1; ud = 1; end
      7'h13: begin
        d.regwrite = 1; d.alusrc = 1;
        d.aluop = {(ins[14:12] == 3'd5) ? ins[30] : 1'b0, ins[14:12]};
        d.imm = 64'($signed(ins[31:20])); u1 = 1; ud = 1;
      end
      7'h03: begin
        d.memread = 1; d.memtoreg = 1; d.regwrite = 1; d.alusrc = 1;
        d.imm = 64'($signed(ins[31:20])); u1 = 1; ud = 1;
      end
      7'h23: begin
        d.memwrite = 1; d.alusrc = 1;
        d.imm = 64'($signed({ins[31:25], ins[11:7]})); u1 = 1; u2 = 1;
      end
      7'h63: begin
        d.branch = 1; d.aluop = 4'd8;
        d.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); u1 = 1; u2 = 1;
      end
      7'h6F: begin
        d.jump = 1; d.regwrite = 1;
        d.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); ud = 1;
      end
      7'h67: begin
        d.jump = 1; d.regwrite = 1; d.alusrc = 1;
        d.imm = 64'($signed(ins[31:20])); u1 = 1; ud = 1;
      end
      7'h37, 7'h17: begin
        d.regwrite = 1; d.alusrc = 1;
        d.imm = 64'($signed({ins[31:12], 12'd0})); ud = 1;
      end
      default: d.illegal = 1;
    endcase
    if (u1) d.rs1 = ins[19:15];
    if (u2) d.rs2 = ins[24:20];
    if (ud) d.rd  = ins[11:7];
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model's head entry.
  task automatic compare_cycle();
    dec_t d;
    logic [63:0] pc;
    bit haz, ev;
    d = '0; pc = '0; haz = 0;
    if (q_instr.size() > 0) begin
      d  = ref_decode(q_instr[0]);
      pc = q_pc[0];
    end
`ifdef ID_HAZARD_STALL_EN
    haz = (q_instr.size() > 0) && ex_memread && (ex_rd != 5'd0) &&
          (ex_rd == d.rs1 || ex_rd == d.rs2);
`endif
    ev = (q_instr.size() > 0) && !haz;
    chk("out_valid", 64'(o_valid), 64'(ev));
    chk("in_ready", 64'(i_ready), 64'(m_in_ready));
    chk("ctrl", 64'({o_branch, o_jump, o_memread, o_memtoreg, o_memwrite, o_alusrc,
                     o_regwrite, o_illegal, o_aluop, o_func3}),
        64'({d.branch, d.jump, d.memread, d.memtoreg, d.memwrite, d.alusrc,
             d.regwrite, d.illegal, d.aluop, d.func3}));
    chk("imm", 64'(o_imm), 64'(d.imm[31:0]));
    chk("regs", 64'({o_rs1, o_rs2, o_rd}), 64'({d.rs1, d.rs2, d.rd}));
    chk("pc", 64'(o_pc), 64'(pc[31:0]));
    chk("x64_hs", 64'({w_valid, w_ready}), 64'({ev, m_in_ready}));
    chk("x64_ctrl", 64'({w_branch, w_jump, w_memread, w_memtoreg, w_memwrite, w_alusrc,
                         w_regwrite, w_illegal, w_aluop, w_func3, w_rs1, w_rs2, w_rd}),
        64'({d.branch, d.jump, d.memread, d.memtoreg, d.memwrite, d.alusrc,
             d.regwrite, d.illegal, d.aluop, d.func3, d.rs1, d.rs2, d.rd}));
    chk("x64_imm", w_imm, d.imm);
    chk("x64_pc", w_pc, pc);
    exp_fire = ev && out_ready;
    exp_acc  = in_valid && m_in_ready;
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    if (reset || flush) begin
      q_instr.delete();
      q_pc.delete();
      m_in_ready = 1'b1;
    end else begin
      if (exp_fire) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (exp_acc) begin
        q_instr.push_back(in_instr);
        q_pc.push_back(in_pc);
      end
      m_in_ready = (q_instr.size() < 2);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] r;
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    r = $urandom;
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic drain();
    in_valid = 0; flush = 0; out_ready = 1; ex_memread = 0;
    repeat (3) step();
  endtask

  int seen_valid;

  initial begin
    reset = 1; in_valid = 0; flush = 0; ex_memread = 0; ex_rd = 0; out_ready = 1;
    in_instr = '0; in_pc = '0;
    @(posedge clk);
    @(posedge clk);
    q_instr.delete(); q_pc.delete(); m_in_ready = 1'b1;
    #1;
    reset = 0;
    chk("reset_out_valid", 64'(o_valid), 64'd0);
    chk("reset_in_ready", 64'(i_ready), 64'd1);
    chk("reset_imm", 64'(o_imm), 64'd0);
    chk("reset_regwrite", 64'(o_regwrite), 64'd0);

    in_valid = 1; in_instr = 32'hFFF00093; in_pc = 64'h100;
    step();
    in_valid = 0;
    chk("addi_valid", 64'(o_valid), 64'd1);
    chk("addi_imm", 64'(o_imm), 64'hFFFFFFFF);
    chk("addi_imm64", w_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_ctl", 64'({o_regwrite, o_alusrc, o_aluop}), 64'h30);
    chk("addi_rd_rs1", 64'({o_rd, o_rs1}), 64'({5'd1, 5'd0}));

    in_valid = 1; in_instr = 32'h407302B3; in_pc = 64'h104;
    step();
    chk("sub_aluop", 64'(o_aluop), 64'h8);
    chk("sub_regs", 64'({o_rs1, o_rs2, o_rd, o_alusrc}), 64'({5'd6, 5'd7, 5'd5, 1'b0}));
    in_instr = 32'h12345237; in_pc = 64'h108;
    step();
    in_valid = 0;
    chk("lui_imm", 64'(o_imm), 64'h12345000);
    chk("lui_rs1_rd", 64'({o_rs1, o_rd}), 64'({5'd0, 5'd4}));
    drain();

    out_ready = 0; in_valid = 1; in_instr = 32'h0000A103; in_pc = 64'h200;
    step();
    in_instr = 32'h001101B3; in_pc = 64'h204;
    step();
    in_valid = 0;
    chk("skid_full_in_ready", 64'(i_ready), 64'd0);
    chk("lw_first_rd", 64'(o_rd), 64'd2);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("add_second_rd", 64'({o_rs1, o_rs2, o_rd}), 64'({5'd2, 5'd1, 5'd3}));
    chk("skid_release_in_ready", 64'(i_ready), 64'd1);

    ex_memread = 1; ex_rd = 2; out_ready = 1;
    #1;
`ifdef ID_HAZARD_STALL_EN
    chk("hazard_stall", 64'(o_valid), 64'd0);
    step();
    chk("hazard_held", 64'(o_valid), 64'd0);
    ex_memread = 0;
    #1;
    chk("hazard_release", 64'(o_valid), 64'd1);
    ex_memread = 1;
`else
    chk("no_stall_logic", 64'(o_valid), 64'd1);
`endif
    ex_rd = 0;
    #1;
    chk("hazard_x0", 64'(o_valid), 64'd1);
    drain();

    out_ready = 0; in_valid = 1;
    in_instr = 32'h00100093; step();
    in_instr = 32'h00200113; step();
    in_instr = 32'h00300193; flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flush_out_valid", 64'(o_valid), 64'd0);
    chk("flush_in_ready", 64'(i_ready), 64'd1);
    out_ready = 1; seen_valid = 0;
    repeat (3) begin
      step();
      seen_valid += int'(o_valid);
    end
    chk("flush_no_issue", 64'(seen_valid), 64'd0);

    in_valid = 1; in_instr = 32'h0000007F; step();
    in_valid = 0;
    chk("illegal_flag", 64'(o_illegal), 64'd1);
    chk("illegal_ctl", 64'({o_branch, o_jump, o_memread, o_memtoreg, o_memwrite,
                            o_alusrc, o_regwrite, o_aluop}), 64'd0);
    chk("illegal_imm_regs", 64'({o_imm, o_rs1, o_rs2, o_rd}), 64'd0);
    drain();

    in_valid = 1; in_instr = 32'h80000063; step();
    in_valid = 0;
    chk("branch_imm64", w_imm, 64'hFFFFFFFFFFFFF000);
    chk("branch_imm32", 64'(o_imm), 64'hFFFFF000);
    chk("branch_ctl", 64'({o_branch, o_aluop}), 64'h18);
    drain();

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_rd      = 5'($urandom_range(0, 7));
      in_instr   = rand_instr();
      in_pc      = {$urandom, $urandom};
      step();
    end
    reset = 0; flush = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
